// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART types: arbiter state encoding and index-width helper.
// HEADER state exists only when UART_TX_ARB_ID_HEADER_EN is defined.
package uart_pkg;

`ifdef UART_TX_ARB_ID_HEADER_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    STREAM = 2'd2
  } uart_tx_arb_state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd2
  } uart_tx_arb_state_t;
`endif

  // Index width for n items; never less than one bit.
  function automatic int unsigned uart_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/TX-FIFO bundle for uart_tx_arbiter. Master drives requests and
// fifo_full; slave (the arbiter) drives ready, FIFO write and status.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WORD_WIDTH = 8
);
  localparam int unsigned GW = uart_idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*WORD_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_we;
  logic [WORD_WIDTH-1:0]         fifo_din;
  logic                          busy;
  logic [GW-1:0]                 grant_id;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_we, fifo_din, busy, grant_id
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_we, fifo_din, busy, grant_id
  );
endinterface

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first set request after last_grant,
// wrapping modulo NUM_REQ.
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned GW     = uart_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic               found,
  output logic [GW-1:0]      winner
);

  int unsigned   idx;
  logic [GW-1:0] cand;

  // Scan farthest-first so the nearest candidate after last_grant wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int unsigned i = NUM_REQ; i >= 1; i--) begin
      idx  = (int'(last_grant) + i) % NUM_REQ;
      cand = GW'(idx);
      if (req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin message arbiter sharing one UART TX FIFO between NUM_REQ
// requesters. Define UART_TX_ARB_ID_HEADER_EN to prefix each message with grant_id.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WORD_WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned GW = uart_idx_w(NUM_REQ);

  uart_tx_arb_state_t state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic               busy_q, busy_d;

  logic               pick_found;
  logic [GW-1:0]      pick_idx;
  logic               g_valid;
  logic               g_last;
  logic [WORD_WIDTH-1:0] g_data;

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .found      (pick_found),
    .winner     (pick_idx)
  );

  always_comb begin
    g_valid = bus.req_valid[grant_q];
    g_last  = bus.req_last[grant_q];
    g_data  = bus.req_data[int'(grant_q)*WORD_WIDTH +: WORD_WIDTH];
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    bus.req_ready = '0;
    bus.fifo_we   = 1'b0;
    bus.fifo_din  = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
`ifdef UART_TX_ARB_ID_HEADER_EN
          state_d = HEADER;
`else
          state_d = STREAM;
`endif
        end
      end
`ifdef UART_TX_ARB_ID_HEADER_EN
      HEADER: begin
        if (!bus.fifo_full) begin
          bus.fifo_we  = 1'b1;
          bus.fifo_din = WORD_WIDTH'(grant_q);
          state_d      = STREAM;
        end
      end
`endif
      STREAM: begin
        bus.req_ready[grant_q] = ~bus.fifo_full;
        if (g_valid && !bus.fifo_full) begin
          bus.fifo_we  = 1'b1;
          bus.fifo_din = g_data;
          if (g_last) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter; header-mode expectations
// follow UART_TX_ARB_ID_HEADER_EN.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int WW = 8;
`ifdef UART_TX_ARB_ID_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       first;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .WORD_WIDTH(WW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .WORD_WIDTH(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int prev_end = -100;
  int msg_first_cyc = -1;
  int last_we_cyc   = -1;
  int start;

  exp_t          sb[$];
  logic [8:0]    rq[NR][$];
  logic [NR-1:0] hold = '0;
  logic [NR-1:0] acc  = '0;

  logic          s_busy, s_we;
  logic [1:0]    s_gid;
  logic [NR-1:0] s_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_msg(input int id, input int n, input logic [7:0] base);
    exp_t e;
    if (HDR != 0) begin
      e.id = id[1:0]; e.data = 8'(id); e.first = 1'b1; e.last = 1'b0;
      sb.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      e.id    = id[1:0];
      e.data  = base + 8'(k);
      e.first = (HDR == 0) && (k == 0);
      e.last  = (k == n - 1);
      sb.push_back(e);
    end
  endtask

  task automatic send(input int id, input int n, input logic [7:0] base);
    expect_msg(id, n, base);
    for (int k = 0; k < n; k++) rq[id].push_back({k == n - 1, base + 8'(k)});
  endtask

  // Requester model: pop accepted words, keep valid stable until accepted.
  task automatic refresh();
    logic keep;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) void'(rq[i].pop_front());
      keep = bus.req_valid[i] && !acc[i];
      if (rq[i].size() > 0 && (keep || !hold[i])) begin
        bus.req_valid[i]         = 1'b1;
        bus.req_data[i*WW +: WW] = rq[i][0][7:0];
        bus.req_last[i]          = rq[i][0][8];
      end else begin
        bus.req_valid[i]         = 1'b0;
        bus.req_data[i*WW +: WW] = '0;
        bus.req_last[i]          = 1'b0;
      end
    end
    acc = '0;
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    acc     = bus.req_valid & bus.req_ready;
    s_busy  = bus.busy;
    s_we    = bus.fifo_we;
    s_gid   = bus.grant_id;
    s_ready = bus.req_ready;
    if (!rst) begin
      chk("ready_onehot", 32'(bus.req_ready & ~(4'b0001 << bus.grant_id)), 0);
      if (bus.fifo_we) begin
        chk("we_while_full", 32'(bus.fifo_full), 0);
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("din", 32'(bus.fifo_din), 32'(e.data));
          chk("grant_id", 32'(bus.grant_id), 32'(e.id));
          if (e.first) begin
            chk("bubble", 32'(cyc - prev_end >= 2), 1);
            msg_first_cyc = cyc;
          end
          if (e.last) prev_end = cyc;
        end
        last_we_cyc = cyc;
      end else begin
        chk("din_idle", 32'(bus.fifo_din), 0);
      end
    end
    @(posedge clk);
    #1;
    refresh();
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && (sb.size() != 0 || bus.busy); k++) step();
    chk("drain_timeout", 32'(sb.size()), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) rq[i].delete();
    sb.delete();
    hold = '0;
    acc  = '0;
    refresh();
    repeat (2) step();
    rst = 1'b0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
    #1;
    do_reset();
    step();
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_grant", 32'(s_gid), 0);
    chk("rst_we", 32'(s_we), 0);
    chk("rst_ready", 32'(s_ready), 0);

    // Three-word message from requester 0.
    start = cyc + 1;
    send(0, 3, 8'h41);
    refresh();
    repeat (4 + HDR) step();
    chk("t1_first_we", 32'(msg_first_cyc), 32'(start + 1));
    chk("t1_last_we", 32'(last_we_cyc), 32'(start + 3 + HDR));
    step();
    chk("t1_busy_fall", 32'(s_busy), 0);

    // All four valid: order 0,1,2,3,0 with one idle cycle per message.
    do_reset();
    start = cyc + 1;
    send(0, 2, 8'h10);
    send(1, 2, 8'h20);
    send(2, 2, 8'h30);
    send(3, 2, 8'h40);
    send(0, 2, 8'h50);
    refresh();
    wait_done(100);
    chk("t2_end", 32'(last_we_cyc), 32'(start + 5 * (3 + HDR) - 1));

    // FIFO full for 5 cycles during requester 2's second word.
    send(2, 3, 8'h60);
    refresh();
    repeat (2 + HDR) step();
    bus.fifo_full = 1'b1;
    repeat (5) begin
      step();
      chk("t3_ready_full", 32'(s_ready[2]), 0);
      chk("t3_we_full", 32'(s_we), 0);
    end
    bus.fifo_full = 1'b0;
    step();
    chk("t3_resume", 32'(last_we_cyc), 32'(cyc));
    wait_done(50);

    // Requester 1 pauses mid-message; requester 3 must wait.
    send(1, 3, 8'h70);
    refresh();
    repeat (1 + HDR) step();
    hold[1] = 1'b1;
    send(3, 1, 8'h7f);
    refresh();
    step();
    repeat (4) begin
      step();
      chk("t4_grant_hold", 32'(s_gid), 1);
      chk("t4_busy_hold", 32'(s_busy), 1);
      chk("t4_we_hold", 32'(s_we), 0);
      chk("t4_ready3", 32'(s_ready[3]), 0);
    end
    hold[1] = 1'b0;
    wait_done(50);

    // Reset during requester 1's second word.
    send(1, 3, 8'h80);
    refresh();
    repeat (2 + HDR) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    expect_msg(0, 1, 8'h90);
    rq[0].push_back({1'b1, 8'h90});
    expect_msg(1, 1, 8'h82);
    expect_msg(3, 1, 8'h93);
    rq[3].push_back({1'b1, 8'h93});
    refresh();
    step();
    chk("t5_we", 32'(s_we), 0);
    chk("t5_busy", 32'(s_busy), 0);
    chk("t5_grant", 32'(s_gid), 0);
    wait_done(60);

    // Single-word message from requester 3 (header 0x03 first when enabled).
    start = cyc + 1;
    send(3, 1, 8'h55);
    refresh();
    repeat (2 + HDR) step();
    chk("t6_first", 32'(msg_first_cyc), 32'(start + 1));
    chk("t6_last", 32'(last_we_cyc), 32'(start + 1 + HDR));
    step();
    chk("t6_busy", 32'(s_busy), 0);
    chk("t6_sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
